reg8_share_arb: RTL and testbench

Round-robin write arbiter that shares a single WIDTH-bit asynchronously-resettable data register among NREQ requesters. Each cycle it grants at most one requester. The winner's data is captured into the shared register on that clock edge. A requester may lock the register for back-to-back exclusive writes. The block sits in front of the 8-bit storage flop and replaces direct multi-driver access to it.

---
 rtl/reg8_share_arb.sv | 136 +++++++++++++
 tb/tb_reg8_share_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg8_share_arb.sv
// Round-robin write arbiter that shares one WIDTH-bit register among NREQ requesters.
// A winner may lock the register for back-to-back exclusive writes.

module reg8_share_arb_lane #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int PW    = 2,
    parameter int IDX   = 0
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PW-1:0]    ptr,
    input  logic [PW-1:0]    owner,
    input  logic             locked,
    input  logic             en,
    input  logic [WIDTH-1:0] d_lane,
    output logic             gnt,
    output logic [WIDTH-1:0] d_sel
);
    localparam logic [PW-1:0] MY_IDX = PW'(IDX);

    // Position of requester j in the rotating scan that starts at ptr.
    function automatic int scan_pos(input int j, input logic [PW-1:0] p);
        int r;
        r = j + NREQ - int'(p);
        if (r >= NREQ) r = r - NREQ;
        return r;
    endfunction

    logic blocked;
    int   my_pos;

    always_comb begin
        blocked = 1'b0;
        my_pos  = scan_pos(IDX, ptr);
        for (int j = 0; j < NREQ; j++) begin
            if (j != IDX && req[j] && scan_pos(j, ptr) < my_pos)
                blocked = 1'b1;
        end
        if (!en)
            gnt = 1'b0;
        else if (locked)
            gnt = req[IDX] && (owner == MY_IDX);
        else
            gnt = req[IDX] && !blocked;
        d_sel = gnt ? d_lane : '0;
    end
endmodule

module reg8_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    d,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     q_upd,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     locked
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {OPEN, LOCKED} mode_t;

    mode_t                       mode, mode_nxt;
    logic [PW-1:0]               ptr, ptr_nxt;
    logic [PW-1:0]               win_idx;
    logic                        wr;
    logic [WIDTH-1:0]            wr_data;
    logic [NREQ-1:0][WIDTH-1:0]  d_sel;

    assign locked = (mode == LOCKED);

    // One arbitration slice per requester; each decides its own grant.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_lane
            reg8_share_arb_lane #(
                .NREQ (NREQ),
                .WIDTH(WIDTH),
                .PW   (PW),
                .IDX  (i)
            ) u_lane (
                .req   (req),
                .ptr   (ptr),
                .owner (owner),
                .locked(locked),
                .en    (areset_n),
                .d_lane(d[i*WIDTH +: WIDTH]),
                .gnt   (gnt[i]),
                .d_sel (d_sel[i])
            );
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) win_idx = PW'(i);
            wr_data = wr_data | d_sel[i];
        end
        wr      = |gnt;
        ptr_nxt = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
    end

    // Lock exit looks only at the owner's lock bit, write or no write.
    always_comb begin
        mode_nxt = mode;
        case (mode)
            OPEN:    if (wr && lock[win_idx]) mode_nxt = LOCKED;
            LOCKED:  if (!lock[owner])        mode_nxt = OPEN;
            default: mode_nxt = OPEN;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            mode  <= OPEN;
            ptr   <= '0;
            owner <= '0;
            q     <= '0;
            q_upd <= 1'b0;
        end else begin
            mode  <= mode_nxt;
            q_upd <= wr;
            if (wr) begin
                q     <= wr_data;
                owner <= win_idx;
                ptr   <= ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_reg8_share_arb.sv
// Self-checking bench for reg8_share_arb: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.

module tb_reg8_share_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    areset_n;
    logic [NREQ-1:0]         req, lock;
    logic [NREQ*WIDTH-1:0]   d;
    logic [NREQ-1:0]         gnt;
    logic [WIDTH-1:0]        q;
    logic                    q_upd;
    logic [1:0]              owner;
    logic                    locked;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit             m_locked;
    int             m_ptr, m_owner;
    logic [7:0]     m_q;
    bit             m_upd;

    reg8_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .areset_n(areset_n), .req(req), .lock(lock), .d(d),
        .gnt(gnt), .q(q), .q_upd(q_upd), .owner(owner), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] m_gnt();
        logic [NREQ-1:0] g;
        bit found;
        g = '0;
        found = 0;
        if (m_locked) g[m_owner] = req[m_owner];
        else
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (!found && req[idx]) begin g[idx] = 1'b1; found = 1; end
            end
        return g;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ptr = 0; m_owner = 0; m_q = '0; m_upd = 0;
    endtask

    task automatic model_edge();
        logic [NREQ-1:0] g;
        int w;
        bit nl;
        g = m_gnt();
        w = -1;
        for (int k = 0; k < NREQ; k++) if (g[k]) w = k;
        nl = m_locked;
        if (m_locked) begin
            if (!lock[m_owner]) nl = 0;
        end else if (w >= 0 && lock[w]) nl = 1;
        if (w >= 0) begin
            m_q = d[w*WIDTH +: WIDTH];
            m_upd = 1;
            m_owner = w;
            m_ptr = (w + 1) % NREQ;
        end else m_upd = 0;
        m_locked = nl;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        d[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic pulse_reset();
        req = '0; lock = '0;
        areset_n = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (q !== 8'h00 || gnt !== 4'b0000 || locked !== 1'b0) begin errors++; $display("FAIL reset_init got q=%h gnt=%b locked=%b exp q=00 gnt=0000 locked=0", q, gnt, locked); end
        @(negedge clk); areset_n = 1'b1; model_reset();
        @(posedge clk); #1;
        req = 4'b0001; set_d(0, 8'hA5);
        step();
        checks++; if (q !== 8'hA5 || q_upd !== 1'b1) begin errors++; $display("FAIL reset_prewrite got q=%h q_upd=%b exp q=a5 q_upd=1", q, q_upd); end
        #2;
        areset_n = 1'b0;
        #1;
        checks++; if (q !== 8'h00 || gnt !== 4'b0000 || q_upd !== 1'b0 || locked !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL reset_async got q=%h gnt=%b q_upd=%b locked=%b owner=%0d exp all zero", q, gnt, q_upd, locked, owner); end
        model_reset();
        req = '0;
        @(negedge clk); areset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        d = {$urandom, $urandom} ;
        set_d(2, 8'h3C);
        req = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        step();
        checks++; if (q !== 8'h3C || q_upd !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL single_write got q=%h upd=%b owner=%0d exp q=3c upd=1 owner=2", q, q_upd, owner); end
        req = '0;
        step();
        checks++; if (q_upd !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL single_hold got q=%h upd=%b exp q=3c upd=0", q, q_upd); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_d(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] eg;
            logic [7:0] eq;
            eg = 4'b0001 << (c % 4);
            eq = 8'h10 + 8'(c % 4);
            #1;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, gnt, eg); end
            step();
            checks++; if (q !== eq || q_upd !== 1'b1) begin errors++; $display("FAIL rr_q[%0d] got q=%h upd=%b exp q=%h upd=1", c, q, q_upd, eq); end
        end
        req = '0;
        step();
    endtask

    task automatic test_lock();
        d = {$urandom, $urandom};
        req = 4'b0001; lock = '0;
        step();
        req = 4'b1111; lock = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) lock = 4'b0000;
            #1;
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d] got=%b exp=0010", c, gnt); end
            step();
            checks++; if (owner !== 2'd1 || locked !== (c < 3) || q !== d[15:8]) begin errors++; $display("FAIL lock_state[%0d] got owner=%0d locked=%b q=%h exp owner=1 locked=%b q=%h", c, owner, locked, q, (c < 3), d[15:8]); end
        end
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_next got=%b exp=0100", gnt); end
        step();
        req = '0;
    endtask

    task automatic test_lock_release();
        req = 4'b1000; lock = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rel_gnt3 got=%b exp=1000", gnt); end
        step();
        checks++; if (locked !== 1'b1 || owner !== 2'd3) begin errors++; $display("FAIL rel_locked got locked=%b owner=%0d exp 1/3", locked, owner); end
        req = 4'b0001; lock = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rel_blocked got=%b exp=0000", gnt); end
        step();
        checks++; if (locked !== 1'b0 || q_upd !== 1'b0) begin errors++; $display("FAIL rel_drop got locked=%b upd=%b exp 0/0", locked, q_upd); end
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rel_next got=%b exp=0001", gnt); end
        step();
        checks++; if (q !== d[7:0] || owner !== 2'd0) begin errors++; $display("FAIL rel_write got q=%h owner=%0d exp q=%h owner=0", q, owner, d[7:0]); end
        req = '0;
    endtask

    task automatic test_reset_mid_lock();
        req = 4'b0100; lock = 4'b0100;
        step();
        checks++; if (locked !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL rml_setup got locked=%b owner=%0d exp 1/2", locked, owner); end
        #2;
        areset_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || q !== 8'h00 || gnt !== 4'b0000 || owner !== 2'd0) begin errors++; $display("FAIL rml_reset got locked=%b q=%h gnt=%b owner=%0d exp 0/00/0000/0", locked, q, gnt, owner); end
        model_reset();
        req = '0; lock = '0;
        @(negedge clk); areset_n = 1'b1;
        @(posedge clk); #1;
        req = 4'b1010;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rml_first got=%b exp=0010", gnt); end
        step();
        checks++; if (owner !== 2'd1 || q !== d[15:8]) begin errors++; $display("FAIL rml_write got owner=%0d q=%h exp 1/%h", owner, q, d[15:8]); end
        req = '0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset();
            req  = 4'($urandom);
            lock = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'b0000;
            d    = {$urandom, $urandom};
            #1;
            checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", c, gnt, m_gnt()); end
            step();
            checks++; if (q !== m_q || q_upd !== m_upd || owner !== 2'(m_owner) || locked !== m_locked) begin errors++; $display("FAIL rand_state[%0d] got q=%h upd=%b owner=%0d locked=%b exp q=%h upd=%b owner=%0d locked=%b", c, q, q_upd, owner, locked, m_q, m_upd, m_owner, m_locked); end
        end
        req = '0; lock = '0;
    endtask

    initial begin
        areset_n = 1'b0;
        req = '0; lock = '0; d = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_lock_release();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
